zv_decompressor: RTL and testbench

- Zero-value decompressor; inverse of the ZVC line compressor.
- Takes a packed line (nonzero words at low lanes) plus a bubble mask (bit=1 marks a zero word) and re-expands it to the original 128-lane layout, inserting zeros at the masked lanes.
- Sits on the read path between the compressed line buffer and the PE array feeder.
- Two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/zvc_pkg.sv | 14 +
 rtl/zvd_prefix_count.sv | 34 +++
 rtl/zv_decompressor.sv | 114 +++++++++++
 tb/tb_zv_decompressor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zvc_pkg.sv
// zvc_pkg: shared ZVC line geometry, lane-index type and nonzero-count helper.
// Used by both the ZVC compressor and zv_decompressor.
package zvc_pkg;
    localparam int ZVC_WORD_WIDTH = 8;
    localparam int ZVC_LINE_WORDS = 128;
    localparam int ZVC_CNT_WIDTH  = $clog2(ZVC_LINE_WORDS + 1);

    typedef logic [ZVC_LINE_WORDS-1:0][ZVC_CNT_WIDTH-1:0] lane_idx_t;

    function automatic logic [ZVC_CNT_WIDTH-1:0] nz_count(input logic [ZVC_LINE_WORDS-1:0] mask);
        nz_count = '0;
        for (int i = 0; i < ZVC_LINE_WORDS; i++) nz_count += ZVC_CNT_WIDTH'(!mask[i]);
    endfunction
endpackage

// File: rtl/zvd_prefix_count.sv
// zvd_prefix_count: exclusive prefix count of zero mask bits (nonzero lanes) via a log-depth scan.
module zvd_prefix_count #(
    parameter int LINE_WORDS = 128,
    parameter int CNT_WIDTH  = $clog2(LINE_WORDS + 1)
) (
    input  logic [LINE_WORDS-1:0]                i_mask,
    output logic [LINE_WORDS-1:0][CNT_WIDTH-1:0] o_pfx,
    output logic [CNT_WIDTH-1:0]                 o_nz
);
    localparam int LVL = $clog2(LINE_WORDS);

    logic [CNT_WIDTH-1:0] w_sum [LVL+1][LINE_WORDS];

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_leaf
        assign w_sum[0][i] = CNT_WIDTH'(!i_mask[i]);
    end

    // Kogge-Stone inclusive scan; exclusive result is the inclusive sum shifted by one lane
    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        for (genvar i = 0; i < LINE_WORDS; i++) begin : g_lane
            if (i >= (1 << l)) begin : g_add
                assign w_sum[l+1][i] = w_sum[l][i] + w_sum[l][i-(1<<l)];
            end else begin : g_pass
                assign w_sum[l+1][i] = w_sum[l][i];
            end
        end
    end

    assign o_pfx[0] = '0;
    for (genvar i = 1; i < LINE_WORDS; i++) begin : g_out
        assign o_pfx[i] = w_sum[LVL][i-1];
    end
    assign o_nz = w_sum[LVL][LINE_WORDS-1];
endmodule

// File: rtl/zv_decompressor.sv
// zv_decompressor: two-stage zero-value line expander (packed nonzero words + bubble mask -> full line).
// Optional packing-corruption check under `ZVD_PAD_CHECK_EN` adds out_err / err_sticky.
module zv_decompressor
    import zvc_pkg::*;
#(
    parameter int WORD_WIDTH = ZVC_WORD_WIDTH,
    parameter int LINE_WORDS = ZVC_LINE_WORDS,
    parameter int CNT_WIDTH  = $clog2(LINE_WORDS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LINE_WORDS*WORD_WIDTH-1:0] in_comp,
    input  logic [LINE_WORDS-1:0]            in_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] out_line,
    output logic [CNT_WIDTH-1:0]             out_nz_cnt
`ifdef ZVD_PAD_CHECK_EN
    ,
    output logic                             out_err,
    output logic                             err_sticky
`endif
);
    localparam int LW = LINE_WORDS * WORD_WIDTH;

    logic                                 w_adv;
    logic                                 w_accept;
    logic [LINE_WORDS-1:0][CNT_WIDTH-1:0] w_pfx;
    logic [CNT_WIDTH-1:0]                 w_nz;
    logic [LW-1:0]                        w_line;
    logic                                 r_s1_valid;
    logic [LW-1:0]                        r_s1_comp;
    logic [LINE_WORDS-1:0]                r_s1_mask;
    logic [LINE_WORDS-1:0][CNT_WIDTH-1:0] r_s1_pfx;
    logic [CNT_WIDTH-1:0]                 r_s1_nz;
    logic                                 r_out_valid;
    logic [LW-1:0]                        r_out_line;
    logic [CNT_WIDTH-1:0]                 r_out_nz;

    assign w_adv      = !r_out_valid || out_ready;
    assign in_ready   = w_adv || !r_s1_valid;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign out_line   = r_out_line;
    assign out_nz_cnt = r_out_nz;

    zvd_prefix_count #(
        .LINE_WORDS(LINE_WORDS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pfx (
        .i_mask(in_mask),
        .o_pfx (w_pfx),
        .o_nz  (w_nz)
    );

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_expand
        assign w_line[i*WORD_WIDTH +: WORD_WIDTH] =
            r_s1_mask[i] ? '0 : r_s1_comp[int'(r_s1_pfx[i])*WORD_WIDTH +: WORD_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_line  <= '0;
            r_out_nz    <= '0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_adv) r_out_valid <= r_s1_valid;
            if (w_adv && r_s1_valid) begin
                r_out_line <= w_line;
                r_out_nz   <= r_s1_nz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_comp <= in_comp;
            r_s1_mask <= in_mask;
            r_s1_pfx  <= w_pfx;
            r_s1_nz   <= w_nz;
        end
    end

`ifdef ZVD_PAD_CHECK_EN
    logic [LINE_WORDS-1:0] w_bad;
    logic                  r_s1_err;
    logic                  r_out_err;
    logic                  r_err_sticky;

    // Packed lanes below nz must be nonzero, padding lanes at or above nz must be zero
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_chk
        assign w_bad[i] = (CNT_WIDTH'(i) >= w_nz) ? |in_comp[i*WORD_WIDTH +: WORD_WIDTH]
                                                  : ~|in_comp[i*WORD_WIDTH +: WORD_WIDTH];
    end

    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;

    always_ff @(posedge clk) begin
        if (w_accept) r_s1_err <= |w_bad;
        if (reset) begin
            r_out_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_adv && r_s1_valid) r_out_err <= r_s1_err;
            if (r_out_valid && out_ready && r_out_err) r_err_sticky <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_zv_decompressor.sv
// tb_zv_decompressor: directed + random scoreboard bench for zv_decompressor.
// Define ZVD_PAD_CHECK_EN to also exercise out_err / err_sticky.
module tb_zv_decompressor;
    localparam int NW = 128;
    localparam int LB = 1024;

    typedef struct {
        logic [LB-1:0] line;
        logic [7:0]    nz;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [LB-1:0] in_comp;
    logic [NW-1:0] in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [LB-1:0] out_line;
    logic [7:0]    out_nz_cnt;
`ifdef ZVD_PAD_CHECK_EN
    logic          out_err;
    logic          err_sticky;
`endif

    exp_t          sb[$];
    exp_t          mon_e;
    exp_t          e;
    logic [LB-1:0] rc;
    logic [NW-1:0] rm;
    logic [LB-1:0] prev_line;
    logic          prev_stall = 1'b0;
    int            n_checks = 0;
    int            n_errs = 0;

    always #5 clk = ~clk;

    zv_decompressor dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_comp   (in_comp),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_line  (out_line),
        .out_nz_cnt(out_nz_cnt)
`ifdef ZVD_PAD_CHECK_EN
        ,
        .out_err   (out_err),
        .err_sticky(err_sticky)
`endif
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        int d = 0;
        for (int j = NW - 1; j >= 0; j--) if (got[j*8 +: 8] !== exp[j*8 +: 8]) d = j;
        n_checks++;
        assert (got === exp) else begin
            n_errs++;
            $error("FAIL %s: lane %0d observed %h expected %h", tag, d, got[d*8 +: 8], exp[d*8 +: 8]);
        end
    endtask

    // Reference: walk lanes in order, consuming packed words with a running counter
    function automatic exp_t model(input logic [LB-1:0] comp, input logic [NW-1:0] mask);
        exp_t r;
        int   k = 0;
        r.line = '0;
        r.err  = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (!mask[i]) begin
                r.line[i*8 +: 8] = comp[k*8 +: 8];
                k++;
            end
        end
        r.nz = 8'(k);
        for (int j = 0; j < NW; j++) if ((j < k) == (comp[j*8 +: 8] == 8'h00)) r.err = 1'b1;
        return r;
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int j = 0; j < LB / 32; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic send(input logic [LB-1:0] comp, input logic [NW-1:0] mask, input exp_t ex);
        int t = 0;
        in_comp  = comp;
        in_mask  = mask;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk_val("send_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) sb.push_back(ex);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk_val("drain_queue_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_line("stall_hold_line", out_line, prev_line);
                chk_val("stall_hold_valid", 32'(out_valid), 32'd1);
            end
            prev_stall = out_valid && !out_ready;
            prev_line  = out_line;
            if (out_valid && out_ready) begin
                chk_val("output_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk_line("out_line", out_line, mon_e.line);
                    chk_val("out_nz_cnt", 32'(out_nz_cnt), 32'(mon_e.nz));
`ifdef ZVD_PAD_CHECK_EN
                    chk_val("out_err", 32'(out_err), 32'(mon_e.err));
`endif
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_comp   = '0;
        in_mask   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_val("rst_out_valid", 32'(out_valid), 32'd0);
        chk_line("rst_out_line", out_line, '0);
        chk_val("rst_out_nz_cnt", 32'(out_nz_cnt), 32'd0);
        chk_val("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ZVD_PAD_CHECK_EN
        chk_val("rst_err_sticky", 32'(err_sticky), 32'd0);
`endif
        @(posedge clk);
        #1;

        // single nonzero word at lane 0, with two-cycle latency check
        rc = '0;
        rc[7:0] = 8'h5A;
        rm = {{(NW-1){1'b1}}, 1'b0};
        e = model(rc, rm);
        e.line = '0;
        e.line[7:0] = 8'h5A;
        e.nz = 8'd1;
        send(rc, rm, e);
        @(negedge clk);
        chk_val("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_val("lat_cycle2_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // alternating mask: even lane 2k gets k+1, padding lanes hold junk
        rc = '1;
        for (int k = 0; k < 64; k++) rc[k*8 +: 8] = 8'(k + 1);
        rm = {64{2'b10}};
        e = model(rc, rm);
        e.line = '0;
        for (int k = 0; k < 64; k++) e.line[2*k*8 +: 8] = 8'(k + 1);
        e.nz = 8'd64;
        send(rc, rm, e);
        wait_drain();

        // all lanes zero
        rc = rand_line();
        rm = '1;
        e = model(rc, rm);
        e.line = '0;
        e.nz = 8'd0;
        send(rc, rm, e);
        // no zero lanes: line passes through unchanged
        for (int i = 0; i < NW; i++) rc[i*8 +: 8] = 8'(i + 1);
        rm = '0;
        e = model(rc, rm);
        e.line = rc;
        e.nz = 8'd128;
        send(rc, rm, e);
        wait_drain();

        // back-to-back random burst with a 4-cycle output stall
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    rc = rand_line();
                    rm = {$urandom(), $urandom(), $urandom(), $urandom()};
                    send(rc, rm, model(rc, rm));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk_val("stall_in_ready", 32'(in_ready), 32'd0);
                chk_val("stall_out_valid", 32'(out_valid), 32'd1);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset with two lines in flight drops both
        out_ready = 1'b0;
        rc = rand_line();
        rm = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(rc, rm, model(rc, rm));
        rc = rand_line();
        rm = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(rc, rm, model(rc, rm));
        @(negedge clk);
        chk_val("inflight_valid", 32'(out_valid), 32'd1);
        chk_val("inflight_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_val("midrst_out_valid", 32'(out_valid), 32'd0);
        chk_line("midrst_out_line", out_line, '0);
        sb.delete();
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk_val("post_rst_no_output", 32'(out_valid), 32'd0);
`ifdef ZVD_PAD_CHECK_EN
        chk_val("post_rst_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk);
        #1;
        // nz=4 but padding lane 7 nonzero
        rc = '0;
        for (int k = 0; k < 4; k++) rc[k*8 +: 8] = 8'(k + 1);
        rc[7*8 +: 8] = 8'h01;
        rm = ~{{(NW-4){1'b0}}, 4'hF};
        e = model(rc, rm);
        e.err = 1'b1;
        send(rc, rm, e);
        wait_drain();
        @(negedge clk);
        chk_val("pad_sticky_set", 32'(err_sticky), 32'd1);
        @(posedge clk);
        #1;
        rc[7*8 +: 8] = 8'h00;
        e = model(rc, rm);
        e.err = 1'b0;
        send(rc, rm, e);
        wait_drain();
        @(negedge clk);
        chk_val("pad_sticky_held", 32'(err_sticky), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_val("pad_sticky_cleared", 32'(err_sticky), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
